// File: rtl/pipeline_decode_queue.sv
// rtl/pipeline_decode_queue.sv - MIPS decode stage with DEPTH-entry op FIFO and load-use interlock at issue
// Optional: define DECODE_EXT_OPS_EN to decode lui, sltiu and lb.
module pipeline_decode_queue #(
  parameter int DEPTH = 4,
  parameter int LOAD_USE_STALL = 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_signal,
  output logic             out_req,
  output logic [31:0]      out_instr,
  output logic [4:0]       out_wdst,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;

  typedef enum logic {IDLE, ARMED} lu_state_t;

  function automatic logic [12:0] decode(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    decode = '0;
    case (op)
      6'b000000: if (fn != 6'b001000)
        decode = {2'b10, 3'b000, ~|fn[5:2], 1'b0, fn[3:0] ^ {{2{fn[5]}}, 2'b00}, 2'b00};
      6'b001000: decode = 13'b11_1_0_0_0_1_1100_00;
      6'b001100: decode = 13'b11_0_0_0_0_1_1000_00;
      6'b001101: decode = 13'b11_0_0_0_0_1_1001_00;
      6'b001110: decode = 13'b11_0_0_0_0_1_1010_00;
      6'b001010: decode = 13'b11_1_0_0_0_1_0110_00;
      6'b101011: decode = 13'b00_1_0_0_0_1_1100_10;
      6'b100011: decode = 13'b11_1_0_1_0_1_1100_01;
      6'b000011: decode = 13'b01_0_1_0_0_1_1111_00;
`ifdef DECODE_EXT_OPS_EN
      6'b001111: decode = 13'b11_0_0_0_0_1_1011_00;
      6'b001011: decode = 13'b11_1_0_0_0_1_0111_00;
      6'b100000: decode = 13'b11_1_0_1_0_1_1100_01;
`endif
      default:   decode = '0;
    endcase
  endfunction

  logic [31:0]   mem_instr [DEPTH];
  logic [12:0]   mem_sig   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  lu_state_t     state;
  logic [4:0]    ld_dst;
  logic [SW-1:0] stall_cnt;
  logic          push;
  logic          pop;
  logic          stall;
  logic          hazard;
  logic          reads_rs;
  logic          reads_rt;
  logic [5:0]    head_op;

  // Empty queue presents an all-zero head so stale storage never leaks out.
  assign out_signal = (count != '0) ? mem_sig[rd_ptr]   : '0;
  assign out_instr  = (count != '0) ? mem_instr[rd_ptr] : '0;
  assign out_req    = out_signal[1] | out_signal[0];

  always_comb begin
    out_wdst = 5'd0;
    case (out_signal[12:11])
      2'b10:   out_wdst = out_instr[15:11];
      2'b11:   out_wdst = out_instr[20:16];
      2'b01:   out_wdst = 5'd31;
      default: out_wdst = 5'd0;
    endcase
  end

  assign head_op  = out_instr[31:26];
  assign reads_rs = (head_op != 6'b000010) && (head_op != 6'b000011);
  assign reads_rt = (head_op == 6'b000000) || (head_op == 6'b000100) ||
                    (head_op == 6'b000101) || (head_op == 6'b101011);
  assign hazard   = (count != '0) &&
                    ((reads_rs && out_instr[25:21] == ld_dst) ||
                     (reads_rt && out_instr[20:16] == ld_dst));
  assign stall    = (state == ARMED) && hazard && (stall_cnt != '0);

  assign in_ready  = !reset && !flush && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0) && !stall;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= in_instr;
        mem_sig[wr_ptr]   <= decode(in_instr);
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issuing a load arms the interlock; it lingers only while the head keeps matching.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= IDLE;
      ld_dst    <= 5'd0;
      stall_cnt <= '0;
    end else if ((LOAD_USE_STALL > 0) && pop && out_signal[0] && (out_wdst != 5'd0)) begin
      state     <= ARMED;
      ld_dst    <= out_wdst;
      stall_cnt <= SW'(LOAD_USE_STALL);
    end else if (state == ARMED) begin
      if (!hazard || stall_cnt == '0)
        state <= IDLE;
      else
        stall_cnt <= stall_cnt - SW'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_decode_queue.sv
// tb/tb_pipeline_decode_queue.sv - self-checking bench for pipeline_decode_queue
module tb_pipeline_decode_queue;
  localparam int DEPTH = 4;
  localparam int LUS   = 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [12:0]      out_signal;
  logic             out_req;
  logic [31:0]      out_instr;
  logic [4:0]       out_wdst;
  logic [CNT_W-1:0] count;

  pipeline_decode_queue #(.DEPTH(DEPTH), .LOAD_USE_STALL(LUS)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_signal(out_signal),
    .out_req(out_req), .out_instr(out_instr), .out_wdst(out_wdst), .count(count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [12:0] fld(int wb, int se, int lk, int m2r, int sh, int imm,
                                      int alu, int mw, int mr);
    return {wb[1:0], se[0], lk[0], m2r[0], sh[0], imm[0], alu[3:0], mw[0], mr[0]};
  endfunction

  function automatic int opc(logic [31:0] i);
    return int'(i[31:26]);
  endfunction

  function automatic logic [12:0] ref_sig(logic [31:0] i);
    int fn;
    int alu;
    fn = int'(i[5:0]);
    case (opc(i))
      0: begin
        if (fn == 8) return '0;
        alu = (fn % 16) ^ ((fn >= 32) ? 12 : 0);
        return fld(2, 0, 0, 0, (fn / 4 == 0) ? 1 : 0, 0, alu, 0, 0);
      end
      8:  return fld(3, 1, 0, 0, 0, 1, 12, 0, 0);
      12: return fld(3, 0, 0, 0, 0, 1, 8, 0, 0);
      13: return fld(3, 0, 0, 0, 0, 1, 9, 0, 0);
      14: return fld(3, 0, 0, 0, 0, 1, 10, 0, 0);
      10: return fld(3, 1, 0, 0, 0, 1, 6, 0, 0);
      43: return fld(0, 1, 0, 0, 0, 1, 12, 1, 0);
      35: return fld(3, 1, 0, 1, 0, 1, 12, 0, 1);
      3:  return fld(1, 0, 1, 0, 0, 1, 15, 0, 0);
`ifdef DECODE_EXT_OPS_EN
      15: return fld(3, 0, 0, 0, 0, 1, 11, 0, 0);
      11: return fld(3, 1, 0, 0, 0, 1, 7, 0, 0);
      32: return fld(3, 1, 0, 1, 0, 1, 12, 0, 1);
`endif
      default: return '0;
    endcase
  endfunction

  function automatic bit is_load(logic [31:0] i);
`ifdef DECODE_EXT_OPS_EN
    return opc(i) == 35 || opc(i) == 32;
`else
    return opc(i) == 35;
`endif
  endfunction

  function automatic bit ref_req(logic [31:0] i);
    return is_load(i) || opc(i) == 43;
  endfunction

  function automatic logic [4:0] ref_wdst(logic [31:0] i);
    case (opc(i))
      0:  return (int'(i[5:0]) == 8) ? 5'd0 : i[15:11];
      3:  return 5'd31;
      8, 12, 13, 14, 10, 35: return i[20:16];
`ifdef DECODE_EXT_OPS_EN
      15, 11, 32: return i[20:16];
`endif
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit reads_reg(logic [31:0] i, int d);
    bit rs_r;
    bit rt_r;
    rs_r = opc(i) != 2 && opc(i) != 3;
    rt_r = opc(i) == 0 || opc(i) == 4 || opc(i) == 5 || opc(i) == 43;
    return (rs_r && int'(i[25:21]) == d) || (rt_r && int'(i[20:16]) == d);
  endfunction

  // Reference: queue of raw instructions plus the pending load destination and bubbles left.
  logic [31:0] mq[$];
  int pend = 0;
  int rem  = 0;

  function automatic bit m_stall();
    return pend != 0 && rem > 0 && mq.size() > 0 && reads_reg(mq[0], pend);
  endfunction

  always @(posedge clk) begin
    bit st;
    bit po;
    bit pu;
    logic [31:0] h;
    st = m_stall();
    h  = '0;
    po = mq.size() > 0 && !st && out_ready && !flush;
    pu = in_valid && !reset && !flush && mq.size() < DEPTH;
    if (reset || flush) begin
      mq.delete();
      pend = 0;
      rem  = 0;
    end else begin
      if (po) h = mq.pop_front();
      if (st) rem--;
      else if (po && is_load(h) && h[20:16] != 5'd0 && LUS > 0) begin
        pend = int'(h[20:16]);
        rem  = LUS;
      end else begin
        pend = 0;
        rem  = 0;
      end
      if (pu) mq.push_back(in_instr);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(!reset && !flush && mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0 && !m_stall()));
      if (mq.size() > 0) begin
        chk("out_signal", 32'(out_signal), 32'(ref_sig(mq[0])));
        chk("out_instr", out_instr, mq[0]);
        chk("out_wdst", 32'(out_wdst), 32'(ref_wdst(mq[0])));
        chk("out_req", 32'(out_req), 32'(ref_req(mq[0])));
      end
    end
  end

  task automatic cyc(input bit rs, input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    reset = rs; in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    int ops[16];
    int fns[8];
    int op;
    int fn;
    logic [4:0] rs, rt, rd, sh;
    ops = '{0, 0, 8, 12, 13, 14, 10, 43, 35, 35, 3, 2, 4, 5, 15, 11};
    fns = '{32, 34, 36, 37, 42, 0, 2, 8};
    op = ops[$urandom_range(15)];
    if ($urandom_range(9) == 0) op = $urandom_range(63);
    fn = (op == 0) ? fns[$urandom_range(7)] : $urandom_range(63);
    rs = 5'($urandom_range(3));
    rt = 5'($urandom_range(3));
    rd = 5'($urandom_range(3));
    sh = 5'($urandom_range(31));
    return {op[5:0], rs, rt, rd, sh, fn[5:0]};
  endfunction

  initial begin
    // reset state and first push
    cyc(1, 0, 0, 0, 0);
    check_en = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_signal", 32'(out_signal), 0);
    chk("rst_out_wdst", 32'(out_wdst), 0);
    cyc(0, 1, 32'h20010005, 0, 0);
    chk("t1_in_ready", 32'(in_ready), 1);
    chk("t1_latency", 32'(out_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_signal", 32'(out_signal), 32'h1C70);
    chk("t1_wdst", 32'(out_wdst), 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_drained", 32'(count), 0);

    // fill to DEPTH, then offer a push while popping at full
    for (int k = 0; k < DEPTH; k++) cyc(0, 1, 32'h20010000 | k, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_full_count", 32'(count), DEPTH);
    chk("t2_full_ready", 32'(in_ready), 0);
    cyc(0, 1, 32'h200100AA, 1, 0);
    cyc(0, 1, 32'h200100BB, 1, 0);
    chk("t2_pop_at_full", 32'(count), DEPTH - 1);
    cyc(0, 0, 0, 0, 0);
    chk("t2_push_pop", 32'(count), DEPTH - 1);
    for (int k = 0; k < DEPTH - 1; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_drained", 32'(count), 0);

    // load-use bubble
    cyc(0, 1, 32'h8C020000, 0, 0);
    cyc(0, 1, 32'h00421820, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_lw_valid", 32'(out_valid), 1);
    chk("t3_lw_signal", 32'(out_signal), 32'h1D71);
    chk("t3_lw_req", 32'(out_req), 1);
    cyc(0, 0, 0, 1, 0);
    chk("t3_bubble", 32'(out_valid), 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_add_valid", 32'(out_valid), 1);
    chk("t3_add_signal", 32'(out_signal), 32'h1030);
    chk("t3_add_wdst", 32'(out_wdst), 3);
    cyc(0, 0, 0, 0, 0);

    // no bubble: independent regs, and load to $0
    cyc(0, 1, 32'h8C020000, 0, 0);
    cyc(0, 1, 32'h00851820, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_indep_valid", 32'(out_valid), 1);
    cyc(0, 1, 32'h8C000000, 0, 0);
    cyc(0, 1, 32'h00001820, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_lw0_wdst", 32'(out_wdst), 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_r0_valid", 32'(out_valid), 1);
    cyc(0, 0, 0, 0, 0);

    // flush beats a concurrent push
    for (int k = 0; k < 3; k++) cyc(0, 1, 32'h20030001 + k, 0, 0);
    cyc(0, 1, 32'h20050007, 0, 1);
    chk("t5_flush_ready", 32'(in_ready), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_valid", 32'(out_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_push_dropped", 32'(count), 0);

    // lui and jal
    cyc(0, 1, 32'h3C01FFFF, 0, 0);
    cyc(0, 0, 0, 1, 0);
`ifdef DECODE_EXT_OPS_EN
    chk("t6_lui_signal", 32'(out_signal), 32'h186C);
    chk("t6_lui_wdst", 32'(out_wdst), 1);
`else
    chk("t6_lui_signal", 32'(out_signal), 0);
    chk("t6_lui_wdst", 32'(out_wdst), 0);
`endif
    cyc(0, 1, 32'h0C000010, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t6_jal_signal", 32'(out_signal), 32'h0A7C);
    chk("t6_jal_wdst", 32'(out_wdst), 31);
    chk("t6_jal_req", 32'(out_req), 0);
    cyc(0, 0, 0, 0, 0);

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(99) == 0, $urandom_range(2) != 0, rnd_instr(),
          $urandom_range(3) != 0, $urandom_range(40) == 0);
    cyc(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
